// File: rtl/kgp_rf_pkg.sv
`timescale 1ns/1ps
// kgp_rf_pkg: shared sizing and types for the KGP-RISC register file.
package kgp_rf_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = reg_addr_t'(ZERO_REG);

endpackage

// File: rtl/decoder_5_32.sv
`timescale 1ns/1ps
// decoder_5_32: one-hot write-enable decoder, all-zero output when disabled.
module decoder_5_32
  import kgp_rf_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_file_wb.sv
`timescale 1ns/1ps
// reg_file_wb: 32x32 register file with one decoded write port and two async read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_wb
  import kgp_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wr_ack,
  output logic [15:0]       wr_count
);

  logic [NUM_REGS-1:0] dec_we;
  logic [NUM_REGS-1:0] we;
  reg_data_t           regs_q [NUM_REGS];
  reg_data_t           regs_d [NUM_REGS];
  logic                wr_ack_q, wr_ack_d;
  logic [15:0]         wr_count_q, wr_count_d;

  decoder_5_32 u_dec (
    .en   (wr_en),
    .addr (wr_addr),
    .dec  (dec_we)
  );

  // The decoder is address-agnostic; the hardwired-zero slot is masked here.
  assign we = dec_we & ~(NUM_REGS'(1) << ZERO_REG);

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we[i]) regs_d[i] = wr_data;
    end
    wr_ack_d   = wr_en && (wr_addr != ZERO_ADDR);
    wr_count_d = wr_count_q + {15'b0, wr_ack_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q     <= '{default: '0};
      wr_ack_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_ack_q   <= wr_ack_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rs_data = (rs_addr == ZERO_ADDR) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == ZERO_ADDR) ? '0 : regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ack_d && (rs_addr == wr_addr)) rs_data = wr_data;
    if (wr_ack_d && (rt_addr == wr_addr)) rt_data = wr_data;
`endif
  end

  assign wr_ack   = wr_ack_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_file_wb.sv
`timescale 1ns/1ps
// tb_reg_file_wb: directed bench with an array-based reference model checked every cycle.
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data;
  logic        wr_ack;
  logic [15:0] wr_count;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  bit          chk_en  = 1'b0;

  reg_file_wb dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wr_ack   (wr_ack),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of register contents plus ack/count bookkeeping.
  logic [31:0] mem [32];
  logic        m_ack = 1'b0;
  int unsigned m_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      m_ack = 1'b0;
      m_cnt = 0;
    end else if (wr_en && wr_addr != 5'd0) begin
      mem[wr_addr] = wr_data;
      m_ack = 1'b1;
      m_cnt = (m_cnt + 1) % 65536;
    end else begin
      m_ack = 1'b0;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != 5'd0 && wr_addr == a) return wr_data;
`endif
    return mem[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_rs_data", rs_data, model_read(rs_addr));
      chk("cyc_rt_data", rt_data, model_read(rt_addr));
      chk("cyc_wr_ack", {31'b0, wr_ack}, {31'b0, m_ack});
      chk("cyc_wr_count", {16'b0, wr_count}, m_cnt[31:0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles, then every address swept on both ports.
    rst = 1'b0;
    repeat (3) cyc();
    chk_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #0.5;
      chk("rst_rs_zero", rs_data, 32'h0);
      chk("rst_rt_zero", rt_data, 32'h0);
    end
    chk("rst_wr_ack", {31'b0, wr_ack}, 32'h0);
    chk("rst_wr_count", {16'b0, wr_count}, 32'h0);
    rst = 1'b1;
    cyc();

    // Basic write/read of r5.
    wr(5'd5, 32'hDEADBEEF);
    rs_addr = 5'd5; rt_addr = 5'd5;
    #0.5;
    chk("basic_rs", rs_data, 32'hDEADBEEF);
    chk("basic_rt", rt_data, 32'hDEADBEEF);
    chk("basic_ack_hi", {31'b0, wr_ack}, 32'h1);
    chk("basic_count", {16'b0, wr_count}, 32'h1);
    cyc();
    chk("basic_ack_lo", {31'b0, wr_ack}, 32'h0);

    // Writes to r0 are dropped with no ack and no count.
    wr(5'd0, 32'h12345678);
    rs_addr = 5'd0;
    #0.5;
    chk("zero_rs", rs_data, 32'h0);
    chk("zero_ack", {31'b0, wr_ack}, 32'h0);
    chk("zero_count", {16'b0, wr_count}, 32'h1);

    // Decoder isolation: each register gets a distinct pattern.
    for (int k = 1; k < 32; k++) wr(5'(k), 32'h01010101 * k);
    chk("iso_count", {16'b0, wr_count}, 32'd32);
    for (int k = 1; k < 32; k++) begin
      rs_addr = 5'(k);
      rt_addr = 5'(32 - k);
      #0.5;
      chk("iso_rs", rs_data, 32'h01010101 * k);
      chk("iso_rt", rt_data, 32'h01010101 * (32 - k));
    end
    cyc();

    // Same-cycle read and write of r7.
    wr(5'd7, 32'hAAAA0000);
    rs_addr = 5'd7; rt_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000BBBB;
    #0.5;
`ifdef REGFILE_BYPASS_EN
    chk("same_pre_edge", rs_data, 32'h0000BBBB);
`else
    chk("same_pre_edge", rs_data, 32'hAAAA0000);
`endif
    chk("same_rt_other", rt_data, 32'h03030303);
    cyc();
    wr_en = 1'b0;
    #0.5;
    chk("same_post_edge", rs_data, 32'h0000BBBB);

    // Counter wrap: restart from reset, then 65534 + 2 accepted writes.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    cyc();
    for (int i = 0; i < 65534; i++) wr(5'((i % 31) + 1), 32'(i));
    chk("wrap_fffe", {16'b0, wr_count}, 32'h0000FFFE);
    wr(5'd12, 32'h11111111);
    chk("wrap_ffff", {16'b0, wr_count}, 32'h0000FFFF);
    wr(5'd9, 32'h99999999);
    chk("wrap_zero", {16'b0, wr_count}, 32'h0);

    // Async reset between edges with a write pending.
    rs_addr = 5'd9; rt_addr = 5'd12;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rs_clr", rs_data, 32'h0);
    chk("async_rt_clr", rt_data, 32'h0);
    chk("async_count", {16'b0, wr_count}, 32'h0);
    repeat (2) cyc();
    wr_en = 1'b0;
    #1;
    rst = 1'b1;
    cyc();
    chk("post_rel_r9", rs_data, 32'h0);
    chk("post_rel_count", {16'b0, wr_count}, 32'h0);
    chk("post_rel_ack", {31'b0, wr_ack}, 32'h0);
    wr(5'd9, 32'h0BADC0DE);
    chk("post_rel_write", rs_data, 32'h0BADC0DE);
    chk("post_rel_count1", {16'b0, wr_count}, 32'h1);
    cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32 x 32-bit general-purpose register file for the KGP-RISC datapath.
- The write side is the distribution end of the operand-select muxes. A 5-to-32 write decoder demultiplexes the single write-back result into one register.
- Two asynchronous read ports (rs, rt) feed the ALU operand muxes.
- Sits between the write-back stage mux and the decode/execute operand path.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, register count; must equal 2**ADDR_W.
- ZERO_REG, 0, index of the hardwired-zero register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low; asserted when 0.
- wr_en  input  1  write request for this cycle.
- wr_addr  input  ADDR_W  destination register.
- wr_data  input  DATA_W  write-back value.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- wr_ack  output  1  registered; high one cycle after an accepted write to a non-zero register.
- wr_count  output  16  registered count of accepted writes; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst=0, any time, independent of clk):
  - all registers clear to 0.
  - wr_ack=0, wr_count=0.
  - rs_data and rt_data read 0 during reset because the storage is 0.
  - Any write in flight is discarded. The first write after release is taken on the first rising clk edge with rst=1.
- Write decode: the decoder drives one-hot we[NUM_REGS-1:0] = wr_en ? (1<<wr_addr) : 0. we[ZERO_REG] is forced to 0.
- Write timing: on a rising clk edge with we[i]=1, reg[i] <= wr_data. The value is visible on read ports combinationally after that edge; write latency is 1 clock.
- Zero register: writes to ZERO_REG are accepted but ignored. They produce no wr_ack and leave wr_count unchanged. Reads of ZERO_REG always return 0.
- Reads: combinational 32:1 select. rs_data = reg[rs_addr], rt_data = reg[rt_addr]. Both ports may address the same register.
- wr_ack: registered, equal to (wr_en && wr_addr != ZERO_REG) from the previous edge.
- wr_count: increments by 1 on each edge where wr_ack's next value is 1. It is unsigned and wraps modulo 2**16 with no saturation.
- Same-cycle read and write of one address, bypass feature off: the read returns the old value until the edge.
- X/unknown address handling is not required.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If wr_en=1, wr_addr != ZERO_REG and rs_addr==wr_addr, then rs_data = wr_data in the same cycle, before the edge. rt_data is forwarded the same way. Forwarding is combinational and adds no latency.
- Not defined: reads show only stored contents, and same-cycle reads return the pre-write value.
- Both builds must pass the same suite, apart from the bypass scenario whose expected value depends on the build.

Decomposition:
- Package kgp_rf_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS, ZERO_REG.
  - Typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
- One sub-module, decoder_5_32: combinational one-hot write-enable decoder with an enable input. It is instantiated once. The ZERO_REG mask is applied in reg_file_wb.
- Storage, read muxes, ack and counter stay in the top module.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then sweep rs_addr and rt_addr over 0..31 -> all reads 0, wr_ack=0, wr_count=0.
- Basic write/read:
  - Write 32'hDEADBEEF to r5, then read rs=5, rt=5 -> both 32'hDEADBEEF.
  - wr_ack=1 for exactly one cycle; wr_count=1.
- Zero register: write 32'h12345678 to r0 -> rs_data(0)=0, wr_ack stays 0, wr_count unchanged.
- Decoder isolation: write k*32'h01010101 to each rk, k=1..31 -> reading every rk returns its own value; no aliasing.
- Same-cycle read/write: r7 holds 32'hAAAA0000; write 32'h0000BBBB to r7 while rs_addr=7 -> pre-edge rs_data is 32'hAAAA0000 without REGFILE_BYPASS_EN, 32'h0000BBBB with it; post-edge it is 32'h0000BBBB in both builds.
- Async reset mid-operation and counter wrap:
  - Preload wr_count to 16'hFFFE via 65534 writes, then do 2 more writes -> wr_count = 0.
  - Drop rst low between edges with wr_en=1 -> immediate clear; the pending write is not applied after release.
